// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: serial bit-pattern detector with a configuration handshake,
// arm/disarm control, a saturating match counter and optional auto-stop.
//
// Parameters
//   MAX_LEN  maximum pattern length in bits (2..16)
//   CNT_W    width of the match counter and of the stop-after value
//
// Ports
//   clk          clock, all logic on posedge
//   rst          synchronous, active-high reset
//   cfg_valid    configuration request
//   cfg_ready    high exactly while IDLE
//   cfg_pattern  pattern, bit 0 is the last-received bit
//   cfg_len      pattern length in bits (1..MAX_LEN accepted)
//   cfg_stop     matches before auto-stop, 0 = unlimited
//   cfg_err      one-cycle pulse after a handshake carrying an invalid cfg_len
//   arm          start detection (IDLE or DONE)
//   disarm       stop detection, wins over arm and bit_valid
//   bit_valid    qualifies new_bit
//   new_bit      serial input bit
//   detected     registered one-cycle match pulse
//   match_count  matches since last arm, saturating
//   state_o      FSM state: IDLE=0, ARMED=1, DONE=2
//
// Build option
//   SEQ_DETECT_NON_OVERLAP_EN  when defined, every match restarts the fill
//   count so the next match needs len fresh bits; otherwise overlapping
//   matches are reported.
//
// Handshake: a configuration transfer happens on a cycle where cfg_valid and
// cfg_ready are both high; cfg_ready does not depend on cfg_valid, and a
// rejected transfer (bad length) still completes, signalled by cfg_err.

module seq_detect_ctrl #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic [CNT_W-1:0] cfg_stop,
    output logic             cfg_err,
    input  logic             arm,
    input  logic             disarm,
    input  logic             bit_valid,
    input  logic             new_bit,
    output logic             detected,
    output logic [CNT_W-1:0] match_count,
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state_q, state_n;

    logic [MAX_LEN-1:0] shift_q, shift_n;
    logic [LEN_W-1:0]   fill_q, fill_n;
    logic [MAX_LEN-1:0] pat_q, pat_n;
    logic [LEN_W-1:0]   len_q, len_n;
    logic [CNT_W-1:0]   stop_q, stop_n;
    logic [CNT_W-1:0]   count_q, count_n;
    logic               det_q, det_n;
    logic               err_q, err_n;

    logic               cfg_fire;
    logic               cfg_len_ok;
    logic [MAX_LEN-1:0] shifted;
    logic [LEN_W-1:0]   fill_inc;
    logic [MAX_LEN-1:0] len_mask;
    logic               hit;
    logic [CNT_W-1:0]   count_inc;

    assign cfg_fire   = cfg_valid && (state_q == IDLE);
    assign cfg_len_ok = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));

    // Candidate shift/fill values as if this cycle's bit were taken; the
    // match is evaluated on them so the new bit participates.
    assign shifted  = {shift_q[MAX_LEN-2:0], new_bit};
    assign fill_inc = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);

    always_comb begin
        len_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (LEN_W'(i) < len_q);
        end
    end

    assign hit       = (fill_inc >= len_q) && ((shifted & len_mask) == (pat_q & len_mask));
    assign count_inc = count_q + CNT_W'(1);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= '0;
            fill_q  <= '0;
            pat_q   <= '0;
            len_q   <= LEN_W'(MAX_LEN);
            stop_q  <= '0;
            count_q <= '0;
            det_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            shift_q <= shift_n;
            fill_q  <= fill_n;
            pat_q   <= pat_n;
            len_q   <= len_n;
            stop_q  <= stop_n;
            count_q <= count_n;
            det_q   <= det_n;
            err_q   <= err_n;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_n = state_q;
        shift_n = shift_q;
        fill_n  = fill_q;
        pat_n   = pat_q;
        len_n   = len_q;
        stop_n  = stop_q;
        count_n = count_q;
        det_n   = 1'b0;
        err_n   = 1'b0;

        // Config loads before arming, so an arm in the same cycle sees it.
        if (cfg_fire) begin
            if (cfg_len_ok) begin
                pat_n  = cfg_pattern;
                len_n  = cfg_len;
                stop_n = cfg_stop;
            end else begin
                err_n = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (arm) begin
                    state_n = ARMED;
                    shift_n = '0;
                    fill_n  = '0;
                    count_n = '0;
                end
            end
            ARMED: begin
                if (disarm) begin
                    state_n = IDLE;
                end else if (bit_valid) begin
                    shift_n = shifted;
                    fill_n  = fill_inc;
                    if (hit) begin
                        det_n = 1'b1;
`ifdef SEQ_DETECT_NON_OVERLAP_EN
                        fill_n = '0;
`endif
                        // Only a match that actually advances the counter
                        // can reach the stop value; a saturated counter holds.
                        if (count_q != '1) begin
                            count_n = count_inc;
                            if ((stop_q != '0) && (count_inc == stop_q)) begin
                                state_n = DONE;
                            end
                        end
                    end
                end
            end
            DONE: begin
                if (disarm) begin
                    state_n = IDLE;
                end else if (arm) begin
                    state_n = ARMED;
                    shift_n = '0;
                    fill_n  = '0;
                    count_n = '0;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Outputs
    always_comb begin
        cfg_ready   = (state_q == IDLE);
        state_o     = state_q;
        detected    = det_q;
        match_count = count_q;
        cfg_err     = err_q;
    end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// tb_seq_detect_ctrl: randomized and directed bench for seq_detect_ctrl
// (MAX_LEN=8, CNT_W=8). A behavioural model keeps the received bits since
// arm in a queue and compares the tail with the pattern.

module tb_seq_detect_ctrl;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 8;
    localparam int LEN_W   = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             cfg_valid = 1'b0;
    logic             cfg_ready;
    logic [7:0]       cfg_pattern = '0;
    logic [LEN_W-1:0] cfg_len = '0;
    logic [7:0]       cfg_stop = '0;
    logic             cfg_err;
    logic             arm = 1'b0;
    logic             disarm = 1'b0;
    logic             bit_valid = 1'b0;
    logic             new_bit = 1'b0;
    logic             detected;
    logic [7:0]       match_count;
    logic [1:0]       state_o;

    seq_detect_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_stop    (cfg_stop),
        .cfg_err     (cfg_err),
        .arm         (arm),
        .disarm      (disarm),
        .bit_valid   (bit_valid),
        .new_bit     (new_bit),
        .detected    (detected),
        .match_count (match_count),
        .state_o     (state_o)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- model ----------------
    logic [1:0] m_state;
    logic [7:0] m_pat;
    int         m_len;
    logic [7:0] m_stop;
    logic [7:0] m_count;
    logic       m_det;
    logic       m_err;
    int         m_bits[$];

    // scoreboard: expected match_count carried by each predicted pulse
    logic [7:0] exp_q[$];

    int checks = 0;
    int errors = 0;
    int trace_diff = 0;
    int diag_lines = 0;

    function automatic logic tail_matches();
        if (m_bits.size() < m_len) return 1'b0;
        for (int i = 0; i < m_len; i++) begin
            if (m_bits[m_bits.size() - 1 - i] != int'(m_pat[i])) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_step(input logic r, input logic cv, input logic [7:0] pat,
                              input logic [LEN_W-1:0] len, input logic [7:0] stop,
                              input logic a, input logic d, input logic bv, input logic nb);
        if (r) begin
            m_state = 2'd0; m_det = 1'b0; m_err = 1'b0; m_count = 8'd0;
            m_bits.delete(); m_pat = 8'd0; m_len = MAX_LEN; m_stop = 8'd0;
            return;
        end
        m_det = 1'b0;
        m_err = 1'b0;
        if (cv && m_state == 2'd0) begin
            if (len == 0 || len > MAX_LEN) m_err = 1'b1;
            else begin
                m_pat = pat; m_len = int'(len); m_stop = stop;
            end
        end
        case (m_state)
            2'd0: if (a) begin
                m_state = 2'd1; m_bits.delete(); m_count = 8'd0;
            end
            2'd1: if (d) m_state = 2'd0;
            else if (bv) begin
                m_bits.push_back(int'(nb));
                if (m_bits.size() > 16) void'(m_bits.pop_front());
                if (tail_matches()) begin
                    m_det = 1'b1;
`ifdef SEQ_DETECT_NON_OVERLAP_EN
                    m_bits.delete();
`endif
                    if (m_count != 8'hFF) begin
                        m_count = m_count + 8'd1;
                        if (m_stop != 0 && m_count == m_stop) m_state = 2'd2;
                    end
                end
            end
            default: if (d) m_state = 2'd0;
            else if (a) begin
                m_state = 2'd1; m_bits.delete(); m_count = 8'd0;
            end
        endcase
    endtask

    // ---------------- driver ----------------
    task automatic drive_cycle(input logic r, input logic cv, input logic [7:0] pat,
                               input logic [LEN_W-1:0] len, input logic [7:0] stop,
                               input logic a, input logic d, input logic bv, input logic nb);
        rst = r; cfg_valid = cv; cfg_pattern = pat; cfg_len = len; cfg_stop = stop;
        arm = a; disarm = d; bit_valid = bv; new_bit = nb;
        @(posedge clk);
        model_step(r, cv, pat, len, stop, a, d, bv, nb);
        if (m_det) exp_q.push_back(m_count);
        #1;
        if (detected !== m_det || match_count !== m_count || state_o !== m_state ||
            cfg_err !== m_err || cfg_ready !== (m_state == 2'd0)) begin
            trace_diff++;
            if (diag_lines < 10) begin
                diag_lines++;
                $display("trace diff t=%0t det=%b/%b cnt=%0d/%0d st=%0d/%0d err=%b/%b rdy=%b",
                         $time, detected, m_det, match_count, m_count, state_o, m_state,
                         cfg_err, m_err, cfg_ready);
            end
        end
        if (detected === 1'b1) begin
            if (exp_q.size() == 0) trace_diff++;
            else if (exp_q.pop_front() !== match_count) trace_diff++;
        end
        if (exp_q.size() != 0) begin
            trace_diff++;
            exp_q.delete();
        end
    endtask

    task automatic do_reset();
        drive_cycle(1'b1, 1'b0, 8'h0, 4'd0, 8'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask
    task automatic idle();
        drive_cycle(1'b0, 1'b0, 8'h0, 4'd0, 8'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask
    task automatic send_bit(input logic b);
        drive_cycle(1'b0, 1'b0, 8'h0, 4'd0, 8'h0, 1'b0, 1'b0, 1'b1, b);
    endtask
    task automatic load_cfg(input logic [7:0] pat, input logic [LEN_W-1:0] len, input logic [7:0] stop);
        drive_cycle(1'b0, 1'b1, pat, len, stop, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask
    task automatic do_arm();
        drive_cycle(1'b0, 1'b0, 8'h0, 4'd0, 8'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask
    task automatic do_disarm();
        drive_cycle(1'b0, 1'b0, 8'h0, 4'd0, 8'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic check_trace(input string name);
        checks++;
        if (trace_diff !== 0) begin
            errors++;
            $display("FAIL %s_trace: %0d differing cycles, expected 0", name, trace_diff);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        trace_diff = 0;
        do_reset();
        do_reset();
        checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state_o); end
        checks++; if (detected !== 1'b0) begin errors++; $display("FAIL reset_detected: got %b expected 0", detected); end
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_cfg_err: got %b expected 0", cfg_err); end
        checks++; if (match_count !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", match_count); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", cfg_ready); end
        // default config: pattern 0, length 8
        do_arm();
        for (int i = 0; i < 7; i++) send_bit(1'b0);
        checks++; if (detected !== 1'b0) begin errors++; $display("FAIL reset_default_early: got %b expected 0", detected); end
        send_bit(1'b0);
        checks++; if (detected !== 1'b1) begin errors++; $display("FAIL reset_default_len8: got %b expected 1", detected); end
        check_trace("reset");
    endtask

    task automatic test_basic();
        logic [5:0] seq;
        trace_diff = 0;
        seq = 6'b110011;
        do_reset();
        load_cfg(8'b0011_0011, 4'd6, 8'd0);
        do_arm();
        for (int i = 5; i >= 1; i--) send_bit(seq[i]);
        checks++; if (detected !== 1'b0) begin errors++; $display("FAIL basic_early: got %b expected 0", detected); end
        send_bit(seq[0]);
        checks++; if (detected !== 1'b1) begin errors++; $display("FAIL basic_pulse: got %b expected 1", detected); end
        checks++; if (match_count !== 8'd1) begin errors++; $display("FAIL basic_count: got %0d expected 1", match_count); end
        idle();
        checks++; if (detected !== 1'b0) begin errors++; $display("FAIL basic_single: got %b expected 0", detected); end
        check_trace("basic");
    endtask

    task automatic test_overlap();
        logic [5:0] seq;
        int pulses;
        int exp_p;
        trace_diff = 0;
        pulses = 0;
        seq = 6'b101010;
`ifdef SEQ_DETECT_NON_OVERLAP_EN
        exp_p = 1;
`else
        exp_p = 2;
`endif
        do_reset();
        load_cfg(8'b0000_1010, 4'd4, 8'd0);
        do_arm();
        for (int i = 5; i >= 0; i--) begin
            send_bit(seq[i]);
            if (detected === 1'b1) pulses++;
        end
        idle();
        if (detected === 1'b1) pulses++;
        checks++; if (pulses !== exp_p) begin errors++; $display("FAIL overlap_pulses: got %0d expected %0d", pulses, exp_p); end
        checks++; if (match_count !== 8'(exp_p)) begin errors++; $display("FAIL overlap_count: got %0d expected %0d", match_count, exp_p); end
        check_trace("overlap");
    endtask

    task automatic test_stop();
        int pulses;
        int late;
        trace_diff = 0;
        pulses = 0;
        late = 0;
        do_reset();
        load_cfg(8'b0000_0011, 4'd2, 8'd2);
        do_arm();
        for (int k = 0; k < 4; k++) begin
            for (int g = 0; g < int'($urandom_range(3, 0)); g++) begin
                idle();
                if (detected === 1'b1) pulses++;
            end
            send_bit(1'b1);
            if (detected === 1'b1) pulses++;
        end
        for (int k = 0; k < 4; k++) begin
            send_bit(1'b1);
            if (detected === 1'b1) late++;
        end
        checks++; if (pulses !== 2) begin errors++; $display("FAIL stop_pulses: got %0d expected 2", pulses); end
        checks++; if (state_o !== 2'd2) begin errors++; $display("FAIL stop_state: got %0d expected 2", state_o); end
        checks++; if (late !== 0) begin errors++; $display("FAIL stop_done_ignores: got %0d expected 0", late); end
        checks++; if (match_count !== 8'd2) begin errors++; $display("FAIL stop_count: got %0d expected 2", match_count); end
        do_arm();
        checks++; if (state_o !== 2'd1 || match_count !== 8'd0) begin
            errors++; $display("FAIL stop_rearm: got state %0d count %0d expected 1 and 0", state_o, match_count);
        end
        do_disarm();
        checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL stop_disarm: got %0d expected 0", state_o); end
        check_trace("stop");
    endtask

    task automatic test_disarm();
        trace_diff = 0;
        do_reset();
        load_cfg(8'b0000_0011, 4'd2, 8'd0);
        do_arm();
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        // completing bit together with disarm (and arm): disarm wins
        drive_cycle(1'b0, 1'b0, 8'h0, 4'd0, 8'h0, 1'b1, 1'b1, 1'b1, 1'b1);
        checks++; if (detected !== 1'b0) begin errors++; $display("FAIL disarm_no_pulse: got %b expected 0", detected); end
        checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL disarm_state: got %0d expected 0", state_o); end
        checks++; if (match_count !== 8'd1) begin errors++; $display("FAIL disarm_count: got %0d expected 1", match_count); end
        check_trace("disarm");
    endtask

    task automatic test_cfg();
        trace_diff = 0;
        do_reset();
        load_cfg(8'b0000_0101, 4'd3, 8'd0);
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_good_err: got %b expected 0", cfg_err); end
        load_cfg(8'hFF, 4'd9, 8'd0);
        checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_len9_err: got %b expected 1", cfg_err); end
        idle();
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_err_pulse: got %b expected 0", cfg_err); end
        load_cfg(8'hFF, 4'd0, 8'd0);
        checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_len0_err: got %b expected 1", cfg_err); end
        do_arm();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        checks++; if (detected !== 1'b1) begin errors++; $display("FAIL cfg_old_pattern: got %b expected 1", detected); end
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL cfg_ready_armed: got %b expected 0", cfg_ready); end
        load_cfg(8'b0000_0011, 4'd2, 8'd0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        checks++; if (detected !== 1'b1) begin errors++; $display("FAIL cfg_armed_ignored: got %b expected 1", detected); end
        do_disarm();
        // arm together with a config: the new config is used
        drive_cycle(1'b0, 1'b1, 8'b0000_0011, 4'd2, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        send_bit(1'b1); send_bit(1'b1);
        checks++; if (detected !== 1'b1) begin errors++; $display("FAIL cfg_arm_same_cycle: got %b expected 1", detected); end
        check_trace("cfg");
    endtask

    task automatic test_saturate();
        int pulses;
        trace_diff = 0;
        pulses = 0;
        do_reset();
        load_cfg(8'b0000_0001, 4'd1, 8'd0);
        do_arm();
        for (int i = 0; i < 300; i++) begin
            send_bit(1'b1);
            if (detected === 1'b1) pulses++;
        end
        checks++; if (match_count !== 8'd255) begin errors++; $display("FAIL sat_count: got %0d expected 255", match_count); end
        checks++; if (pulses !== 300) begin errors++; $display("FAIL sat_pulses: got %0d expected 300", pulses); end
        drive_cycle(1'b1, 1'b1, 8'h01, 4'd1, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1);
        checks++; if (state_o !== 2'd0 || detected !== 1'b0 || match_count !== 8'd0 || cfg_err !== 1'b0 || cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL sat_midstream_rst: got st=%0d det=%b cnt=%0d err=%b rdy=%b expected 0 0 0 0 1",
                     state_o, detected, match_count, cfg_err, cfg_ready);
        end
        do_arm();
        send_bit(1'b1);
        checks++; if (detected !== 1'b0) begin errors++; $display("FAIL sat_pattern_reset: got %b expected 0", detected); end
        check_trace("saturate");
    endtask

    task automatic test_random();
        trace_diff = 0;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            drive_cycle($urandom_range(99, 0) == 0,
                        $urandom_range(9, 0) == 0,
                        8'($urandom()),
                        4'($urandom_range(10, 0)),
                        8'($urandom_range(4, 0)),
                        $urandom_range(14, 0) == 0,
                        $urandom_range(29, 0) == 0,
                        $urandom_range(1, 0) == 1,
                        $urandom_range(1, 0) == 1);
        end
        check_trace("random");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overlap();
        test_stop();
        test_disarm();
        test_cfg();
        test_saturate();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_detect_ctrl.md
SEQ_DETECT_CTRL -- requirements
Module: seq_detect_ctrl

Interface
REQ-001 SHALL have parameter MAX_LEN, default 8, maximum pattern length in bits (2..16).
REQ-002 SHALL have parameter CNT_W, default 8, width of the match counter and the stop-after value.
REQ-003 SHALL have port clk  input  1  clock; all logic on posedge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port cfg_valid  input  1  configuration request.
REQ-006 SHALL have port cfg_ready  output  1  configuration accepted this cycle when high with cfg_valid.
REQ-007 SHALL have port cfg_pattern  input  MAX_LEN  pattern; bit 0 is the last-received bit.
REQ-008 SHALL have port cfg_len  input  $clog2(MAX_LEN+1)  pattern length in bits.
REQ-009 SHALL have port cfg_stop  input  CNT_W  matches before auto-stop; 0 = unlimited.
REQ-010 SHALL have port cfg_err  output  1  one-cycle pulse: handshake completed with invalid cfg_len.
REQ-011 SHALL have port arm  input  1  start detection.
REQ-012 SHALL have port disarm  input  1  stop detection.
REQ-013 SHALL have port bit_valid  input  1  new_bit qualifier.
REQ-014 SHALL have port new_bit  input  1  serial input bit.
REQ-015 SHALL have port detected  output  1  one-cycle match pulse.
REQ-016 SHALL have port match_count  output  CNT_W  matches since last arm, saturating.
REQ-017 SHALL have port state_o  output  2  FSM state: IDLE=0, ARMED=1, DONE=2.

Function
REQ-018 cfg_ready SHALL be high exactly when in IDLE; configuration SHALL load on cfg_valid & cfg_ready.
REQ-019 cfg_len of 0 or greater than MAX_LEN SHALL be rejected: stored config unchanged, cfg_err pulses the next cycle.
REQ-020 IDLE->ARMED on arm; this SHALL clear the shift register, the fill counter, and match_count.
REQ-021 In ARMED, each bit_valid cycle SHALL shift new_bit into bit 0 and increment the fill counter, saturating at MAX_LEN.
REQ-022 A match SHALL occur when fill >= len and the low len bits of the shift register (including the new bit) equal the low len bits of the pattern.
REQ-023 detected SHALL be registered, asserting for one cycle on the cycle after the bit_valid that completes a match; match_count SHALL update in the same cycle.
REQ-024 match_count SHALL saturate at all-ones and SHALL NOT wrap.
REQ-025 With cfg_stop != 0, the match that brings match_count to cfg_stop SHALL move the FSM ARMED->DONE, taking effect with the detected pulse.
REQ-026 In DONE, bits SHALL be ignored; arm SHALL re-arm per REQ-020, and disarm SHALL return to IDLE.
REQ-027 disarm SHALL move ARMED or DONE to IDLE, and SHALL take priority over bit_valid and arm in the same cycle: no shift, no detection.
REQ-028 arm while ARMED SHALL be ignored; arm in IDLE with cfg_valid in the same cycle SHALL load the config first, and arming SHALL use the new config.
REQ-029 Cycles without bit_valid SHALL leave all state unchanged (gaps are transparent).

Reset
REQ-030 rst SHALL set: state IDLE, detected 0, cfg_err 0, match_count 0, shift register 0, fill 0, pattern 0, len MAX_LEN, stop 0.
REQ-031 rst SHALL take priority over all inputs, including mid-stream while ARMED.

Configuration
REQ-032 Macro SEQ_DETECT_NON_OVERLAP_EN: when defined, each match SHALL reset the fill counter to 0, so the next match needs len fresh bits.
REQ-033 Without SEQ_DETECT_NON_OVERLAP_EN, overlapping matches SHALL be reported; the fill counter is unaffected by matches.

Verification (MAX_LEN=8, CNT_W=8)
REQ-034 Load pattern 6'b110011, len 6, stop 0; arm; stream 1,1,0,0,1,1 -> detected is a single pulse one cycle after the 6th bit, and match_count=1.
REQ-035 Pattern 1010, len 4; stream 1,0,1,0,1,0 -> without macro: 2 pulses, match_count=2; with macro: 1 pulse, match_count=1.
REQ-036 Pattern 11, len 2, stop 2; stream 1,1,1,1 with random bit_valid gaps -> 2 pulses, then state_o=DONE, and further bits produce no pulse.
REQ-037 disarm asserted in the same cycle as the bit that would complete a match -> no detected pulse, state_o=IDLE, match_count unchanged.
REQ-038 cfg_len=9 in IDLE -> cfg_err pulses, and the previous pattern still detects; cfg_valid while ARMED -> cfg_ready=0, config unchanged.
REQ-039 Pattern 1, len 1; 300 one-bits -> match_count saturates at 255; rst mid-stream returns every output to its reset value.
